uncached_wbuf: RTL and testbench

Uncached data-bus backend sitting directly downstream of the data-bus mux's uncached port. It posts uncached stores into a FIFO so the pipeline does not wait for device acknowledgement. It holds uncached loads until all earlier stores are acknowledged, preserving program order to MMIO. It drives a single-outstanding request/response bus toward the uncached AXI bridge.

---
 rtl/uncached_wbuf.sv | 204 ++++++++++++++++++++
 tb/tb_uncached_wbuf.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uncached_wbuf.sv
// Uncached data-bus backend: posts stores into a small FIFO and drains them to a single-outstanding bus.
// Loads wait for earlier stores. Define UNCACHED_WBUF_EN to enable the store buffer; otherwise stores stall like loads.
module uncached_wbuf #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_wrdata,
    input  logic [3:0]  cpu_byteenable,
    input  logic        pipe_stall,
    output logic        cpu_stall,
    output logic [31:0] cpu_rddata,
    output logic        req_valid,
    input  logic        req_ready,
    output logic        req_write,
    output logic [31:0] req_addr,
    output logic [31:0] req_wdata,
    output logic [3:0]  req_be,
    input  logic        resp_valid,
    input  logic [31:0] resp_rdata
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uncached_wbuf: DEPTH must be a power of two and at least 2");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        W_REQ  = 3'd1,
        W_RESP = 3'd2,
        R_REQ  = 3'd3,
        R_RESP = 3'd4,
        R_DONE = 3'd5,
        W_DONE = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic        req_valid_q, req_valid_d;
    logic        req_write_q, req_write_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] req_wdata_q, req_wdata_d;
    logic [3:0]  req_be_q, req_be_d;
    logic [31:0] rddata_q, rddata_d;

    logic        read_go;
    logic        write_go;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    state_t      w_after;

`ifdef UNCACHED_WBUF_EN
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   fifo_addr_q  [DEPTH];
    logic [31:0]   fifo_wdata_q [DEPTH];
    logic [3:0]    fifo_be_q    [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          wr_taken_q, wr_taken_d;
    logic          full, push, pop;

    always_comb begin
        full      = (count_q == CW'(DEPTH));
        push      = cpu_write & ~wr_taken_q & ~full;
        pop       = (state_q == W_RESP) & resp_valid;
        cpu_stall = (cpu_write & ~wr_taken_q & full) | (cpu_read & (state_q != R_DONE));
        // A same-cycle store must reach the buffer before the load may claim the bus.
        read_go   = cpu_read & (count_q == '0) & ~push;
        write_go  = (count_q != '0);
        wr_addr   = fifo_addr_q[rptr_q];
        wr_data   = fifo_wdata_q[rptr_q];
        wr_be     = fifo_be_q[rptr_q];
        w_after   = IDLE;
        count_d   = count_q + CW'(push) - CW'(pop);
        if (!cpu_stall && !pipe_stall) begin
            wr_taken_d = 1'b0;
        end else if (push) begin
            wr_taken_d = 1'b1;
        end else begin
            wr_taken_d = wr_taken_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wptr_q]  <= cpu_address;
            fifo_wdata_q[wptr_q] <= cpu_wrdata;
            fifo_be_q[wptr_q]    <= cpu_byteenable;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            wr_taken_q <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            count_q    <= count_d;
            wr_taken_q <= wr_taken_d;
        end
    end
`else
    always_comb begin
        cpu_stall = (cpu_write & (state_q != W_DONE)) | (cpu_read & (state_q != R_DONE));
        read_go   = cpu_read & ~cpu_write;
        write_go  = cpu_write;
        wr_addr   = cpu_address;
        wr_data   = cpu_wrdata;
        wr_be     = cpu_byteenable;
        w_after   = W_DONE;
    end
`endif

    always_comb begin
        state_d     = state_q;
        req_valid_d = req_valid_q;
        req_write_d = req_write_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_be_d    = req_be_q;
        rddata_d    = rddata_q;
        case (state_q)
            IDLE: begin
                if (read_go) begin
                    state_d     = R_REQ;
                    req_valid_d = 1'b1;
                    req_write_d = 1'b0;
                    req_addr_d  = cpu_address;
                    req_be_d    = 4'hF;
                end else if (write_go) begin
                    state_d     = W_REQ;
                    req_valid_d = 1'b1;
                    req_write_d = 1'b1;
                    req_addr_d  = wr_addr;
                    req_wdata_d = wr_data;
                    req_be_d    = wr_be;
                end
            end
            W_REQ: begin
                if (req_ready) begin
                    state_d     = W_RESP;
                    req_valid_d = 1'b0;
                end
            end
            W_RESP: begin
                if (resp_valid) state_d = w_after;
            end
            R_REQ: begin
                if (req_ready) begin
                    state_d     = R_RESP;
                    req_valid_d = 1'b0;
                end
            end
            R_RESP: begin
                if (resp_valid) begin
                    state_d  = R_DONE;
                    rddata_d = resp_rdata;
                end
            end
            R_DONE: state_d = IDLE;
            // Hold the completion while the store instruction is frozen, so it is not reissued.
            W_DONE: begin
                if (!(cpu_write && pipe_stall)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_valid_q <= 1'b0;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_be_q    <= '0;
            rddata_q    <= '0;
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            req_write_q <= req_write_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_be_q    <= req_be_d;
            rddata_q    <= rddata_d;
        end
    end

    assign req_valid  = req_valid_q;
    assign req_write  = req_write_q;
    assign req_addr   = req_addr_q;
    assign req_wdata  = req_wdata_q;
    assign req_be     = req_be_q;
    assign cpu_rddata = rddata_q;

endmodule

// File: tb/tb_uncached_wbuf.sv
// Scoreboard bench for uncached_wbuf: expected bus requests and load data are queued at issue,
// a bus-model monitor and a load-data monitor pop and compare.
module tb_uncached_wbuf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_read, cpu_write, pipe_stall;
    logic [31:0] cpu_address, cpu_wrdata;
    logic [3:0]  cpu_byteenable;
    logic        cpu_stall;
    logic [31:0] cpu_rddata;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic [31:0] resp_rdata;

    uncached_wbuf #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_address(cpu_address),
        .cpu_wrdata(cpu_wrdata), .cpu_byteenable(cpu_byteenable), .pipe_stall(pipe_stall),
        .cpu_stall(cpu_stall), .cpu_rddata(cpu_rddata),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
    } req_t;

    req_t        exp_q[$];
    logic [31:0] rd_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int ready_mode = 1;   // 0: never ready, 1: always ready, 2: random
    int lat_min = 1, lat_max = 1;
    int hs_count = 0;
    int valid_cnt = 0;
    int inflight = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ready driver
    initial begin
        req_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            req_ready = (ready_mode == 0) ? 1'b0 : (ready_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // bus model + request monitor
    initial begin
        logic        pv, pr, pw;
        logic [31:0] pa, pd, rsp;
        logic [3:0]  pb;
        req_t        e;
        int          lat;
        pv = 0; pr = 0; pw = 0; pa = 0; pd = 0; pb = 0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        forever begin
            @(negedge clk);
            if (req_valid) valid_cnt++;
            if (rst_n && pv && !pr && req_valid) begin
                chk("stable_write", req_write, pw);
                chk("stable_addr", req_addr, pa);
                chk("stable_be", req_be, pb);
                if (pw) chk("stable_wdata", req_wdata, pd);
            end
            pv = req_valid; pr = req_ready; pw = req_write; pa = req_addr; pd = req_wdata; pb = req_be;
            if (rst_n && req_valid && req_ready) begin
                hs_count++;
                chk("single_outstanding", inflight, 0);
                rsp = $urandom;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_req: got addr %h write %b, required none", req_addr, req_write);
                end else begin
                    e = exp_q.pop_front();
                    chk("req_write", req_write, e.wr);
                    chk("req_addr", req_addr, e.addr);
                    chk("req_be", req_be, e.be);
                    if (e.wr) chk("req_wdata", req_wdata, e.wdata);
                    rsp = e.rdata;
                end
                inflight = 1;
                lat = $urandom_range(lat_min, lat_max);
                @(posedge clk);
                repeat (lat - 1) @(posedge clk);
                #1;
                resp_valid = 1'b1;
                resp_rdata = rsp;
                @(posedge clk);
                #1;
                resp_valid = 1'b0;
                inflight = 0;
            end
        end
    end

    // load-data monitor
    initial begin
        logic [31:0] r;
        forever begin
            @(negedge clk);
            if (rst_n && cpu_read && !cpu_stall) begin
                if (rd_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_load_done: got rddata %h, required none", cpu_rddata);
                end else begin
                    r = rd_q.pop_front();
                    chk("cpu_rddata", cpu_rddata, r);
                end
            end
        end
    end

    task automatic wait_accept(input string name, output int stalls);
        int guard;
        stalls = 0;
        guard = 0;
        forever begin
            @(negedge clk);
            if (!cpu_stall) break;
            stalls++;
            guard++;
            if (guard > 400) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s_timeout: got stall after %0d cycles, required release", name, guard);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                            output int stalls);
        req_t e;
        e = '{wr: 1'b1, addr: a, wdata: d, be: be, rdata: 32'h0};
        exp_q.push_back(e);
        cpu_write = 1'b1; cpu_address = a; cpu_wrdata = d; cpu_byteenable = be;
        wait_accept("store", stalls);
        cpu_write = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] rdata, output int stalls);
        req_t e;
        e = '{wr: 1'b0, addr: a, wdata: 32'h0, be: 4'hF, rdata: rdata};
        exp_q.push_back(e);
        rd_q.push_back(rdata);
        cpu_read = 1'b1; cpu_address = a;
        wait_accept("load", stalls);
        cpu_read = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0 && inflight == 0 && !req_valid) break;
            guard++;
            if (guard > 1000) break;
        end
        chk("drain_pending", exp_q.size(), 0);
        step(1);
    endtask

    initial begin
        int st, tot, hs0, shigh;
        int s5[5];
        rst_n = 1'b0;
        cpu_read = 0; cpu_write = 0; pipe_stall = 0;
        cpu_address = 0; cpu_wrdata = 0; cpu_byteenable = 0;
        step(3);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_valid", req_valid, 0);
        chk("rst_req_write", req_write, 0);
        chk("rst_req_addr", req_addr, 0);
        chk("rst_req_wdata", req_wdata, 0);
        chk("rst_req_be", req_be, 0);
        chk("rst_cpu_rddata", cpu_rddata, 0);
        chk("rst_cpu_stall", cpu_stall, 0);
        step(1);

        // reset while a write request is pending and the buffer holds entries
        ready_mode = 0;
        step(1);
        for (int i = 0; i < 3; i++) begin
            cpu_write = 1; cpu_address = 32'hA000 + 32'(i * 4);
            cpu_wrdata = 32'h5500 + 32'(i); cpu_byteenable = 4'hF;
            step(1);
        end
        cpu_write = 0;
        step(3);
        @(negedge clk);
        chk("pre_reset_req_valid", req_valid, 1);
        chk("pre_reset_req_write", req_write, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_req_valid", req_valid, 0);
        chk("async_rst_req_write", req_write, 0);
        chk("async_rst_req_addr", req_addr, 0);
        chk("async_rst_req_wdata", req_wdata, 0);
        chk("async_rst_req_be", req_be, 0);
        chk("async_rst_cpu_stall", cpu_stall, 0);
        exp_q.delete();
        step(2);
        rst_n = 1'b1;
        ready_mode = 1;
        valid_cnt = 0;
        step(20);
        chk("no_req_after_reset", valid_cnt, 0);

        // four back-to-back stores
        ready_mode = 1; lat_min = 1; lat_max = 1;
        tot = 0;
        for (int i = 0; i < 4; i++) begin
            do_store(32'h1000 + 32'(i * 4), $urandom, 4'($urandom_range(1, 15)), st);
            tot += st;
        end
`ifdef UNCACHED_WBUF_EN
        chk("b2b_store_stalls", tot, 0);
`else
        chk("b2b_store_stalls", tot, 12);
`endif
        drain();

        // load with empty buffer, immediate ready, one-cycle ack
        do_load(32'h3000, $urandom, st);
        chk("load_stall_cycles", st, 3);
        drain();

        // five stores against a stalled bus
        ready_mode = 0;
        fork
            for (int i = 0; i < 5; i++) do_store(32'h4000 + 32'(i * 4), $urandom, 4'hF, s5[i]);
            begin
                step(14);
                ready_mode = 1;
            end
        join
`ifdef UNCACHED_WBUF_EN
        chk("full_first4_stalls", s5[0] + s5[1] + s5[2] + s5[3], 0);
        chk("full_fifth_stalled", 32'(s5[4] > 5), 1);
`endif
        drain();

        // store then load next cycle: load must wait for the write ack
        do_store(32'h2000, 32'h1234_5678, 4'hF, st);
        do_load(32'h2004, 32'hDEAD_BEEF, st);
        drain();

`ifdef UNCACHED_WBUF_EN
        // store frozen by pipe_stall enqueues once
        hs0 = hs_count;
        begin
            req_t e;
            e = '{wr: 1'b1, addr: 32'h5000, wdata: 32'hCAFE_0001, be: 4'h3, rdata: 32'h0};
            exp_q.push_back(e);
        end
        cpu_write = 1; cpu_address = 32'h5000; cpu_wrdata = 32'hCAFE_0001; cpu_byteenable = 4'h3;
        pipe_stall = 1;
        shigh = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (cpu_stall) shigh++;
            step(1);
        end
        pipe_stall = 0;
        step(1);
        cpu_write = 0;
        drain();
        chk("pipe_stall_store_stalls", shigh, 0);
        chk("pipe_stall_single_req", hs_count - hs0, 1);
`endif

        // load flushed while in flight
        lat_min = 4; lat_max = 4;
        begin
            req_t e;
            e = '{wr: 1'b0, addr: 32'h6000, wdata: 32'h0, be: 4'hF, rdata: 32'h0BAD_0BAD};
            exp_q.push_back(e);
        end
        cpu_read = 1; cpu_address = 32'h6000;
        step(2);
        cpu_read = 0;
        shigh = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (cpu_stall) shigh++;
            step(1);
        end
        chk("flushed_load_no_stall", shigh, 0);
        do_store(32'h6100, 32'h7777_8888, 4'hC, st);
`ifdef UNCACHED_WBUF_EN
        chk("store_after_flush_stalls", st, 0);
`endif
        drain();

        // randomized mix
        ready_mode = 2; lat_min = 1; lat_max = 3;
        for (int i = 0; i < 80; i++) begin
            int op;
            op = $urandom_range(0, 3);
            if (op <= 1)
                do_store({16'h0, 14'($urandom), 2'b00}, $urandom, 4'($urandom_range(1, 15)), st);
            else if (op == 2)
                do_load({16'h0, 14'($urandom), 2'b00}, $urandom, st);
            else
                step($urandom_range(1, 3));
        end
        drain();
        chk("load_data_pending", rd_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
